// File: rtl/pong_axil_pkg.sv
// Shared types and constants for the pong AXI4-Lite command initiator.
package pong_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/pong_axil_master.sv
// AXI4-Lite initiator: turns one command (write or read) into a single AXI4-Lite
// transaction and returns a one-cycle response pulse. A watchdog flags (but never
// abandons) transactions that take too long.
module pong_axil_master
    import pong_axil_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT            = 256
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    // command / response port
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            timeout_err,
    // AXI4-Lite write channels
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    // AXI4-Lite read channels
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]               wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]                wd_cnt_q, wd_cnt_d;
    logic                            timeout_err_q, timeout_err_d;

    logic aw_hs;
    logic w_hs;

    // Next-state, channel valids, response capture and watchdog
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;

        aw_hs = awvalid_q & m_axi_awready;
        w_hs  = wvalid_q & m_axi_wready;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    wstrb_d  = cmd_wstrb;
                    wd_cnt_d = '0;
                    if (cmd_write) begin
                        state_d   = WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = RADDR;
                    end
                end
            end
            WADDR: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // A dropped valid inside WADDR means that channel's handshake is already recorded.
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                end
            end
            RADDR: begin
                if (m_axi_arready) state_d = RDATA;
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_rdata_d = m_axi_rdata;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            if (wd_cnt_q != CNT_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
            if (wd_cnt_d == CNT_MAX) timeout_err_d = 1'b1;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Held low while reset is asserted so no command is taken during reset.
    assign cmd_ready     = (state_q == IDLE) & m_axi_aresetn;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout_err   = timeout_err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = '0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == WRESP);

    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = '0;
    assign m_axi_arvalid = (state_q == RADDR);
    assign m_axi_rready  = (state_q == RDATA);

endmodule

// File: tb/tb_pong_axil_master.sv
// Directed bench for pong_axil_master with a configurable AXI4-Lite slave model
// and a response scoreboard.
module tb_pong_axil_master;
    import pong_axil_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic          rvalid = 1'b0;
    logic          rready;

    pong_axil_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .timeout_err(timeout_err),
        .m_axi_awaddr(awaddr),
        .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_araddr(araddr),
        .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata),
        .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard of expected responses, pushed at command issue
    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb_q[$];
    logic [DW-1:0] ref_mem [4] = '{default: '0};

    // Slave configuration (written by the stimulus only)
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] bresp_cfg = RESP_OKAY;
    logic [1:0] rresp_cfg = RESP_OKAY;

    // Slave state (posedge process)
    logic [DW-1:0] mem [4] = '{default: '0};
    logic          aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
    logic [AW-1:0] aw_a = '0, ar_a = '0;
    logic [DW-1:0] w_d = '0;
    logic [SW-1:0] w_s = '0;
    int            aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, aw_hi = 0, w_hi = 0;
    logic          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [SW-1:0] p_wstrb = '0;

    // Slave handshake capture, memory update and valid/payload hold checks
    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            ar_got <= 1'b0;
            p_aw   <= 1'b0;
            p_w    <= 1'b0;
            p_ar   <= 1'b0;
        end else begin
            if (p_aw) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
            if (p_w)  check("w_hold", 64'({wvalid, wstrb, wdata}), 64'({1'b1, p_wstrb, p_wdata}));
            if (p_ar) check("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
            p_aw     <= awvalid & ~awready;
            p_w      <= wvalid & ~wready;
            p_ar     <= arvalid & ~arready;
            p_awaddr <= awaddr;
            p_wdata  <= wdata;
            p_wstrb  <= wstrb;
            p_araddr <= araddr;
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid)  w_hi  <= w_hi + 1;
            if (awvalid && awready) begin
                aw_hs_n <= aw_hs_n + 1;
                aw_got  <= 1'b1;
                aw_a    <= awaddr;
            end
            if (wvalid && wready) begin
                w_hs_n <= w_hs_n + 1;
                w_got  <= 1'b1;
                w_d    <= wdata;
                w_s    <= wstrb;
            end
            if (arvalid && arready) begin
                ar_hs_n <= ar_hs_n + 1;
                ar_got  <= 1'b1;
                ar_a    <= araddr;
            end
            if (bvalid && bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                for (int b = 0; b < SW; b++)
                    if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] <= w_d[8*b +: 8];
            end
            if (rvalid && rready) ar_got <= 1'b0;
        end
    end

    int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;

    // Slave ready/valid drive, updated away from the active edge
    always @(negedge clk) begin
        if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end
        else begin awready = 1'b0; aw_c = 0; end
        if (wvalid) begin wready = (w_c >= w_dly); w_c++; end
        else begin wready = 1'b0; w_c = 0; end
        if (arvalid) begin arready = (ar_c >= ar_dly); ar_c++; end
        else begin arready = 1'b0; ar_c = 0; end
        if (aw_got && w_got) begin bvalid = (b_c >= b_dly); b_c++; end
        else begin bvalid = 1'b0; b_c = 0; end
        bresp = bresp_cfg;
        if (ar_got) begin rvalid = (r_c >= r_dly); r_c++; end
        else begin rvalid = 1'b0; r_c = 0; end
        rdata = rvalid ? mem[ar_a[3:2]] : '0;
        rresp = rresp_cfg;
    end

    int   rsp_n    = 0;
    logic prev_rsp = 1'b0;

    // Response monitor: pops the scoreboard on every rsp_valid pulse
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            exp_t e;
            rsp_n++;
            check("rsp_single", 64'(prev_rsp), 64'(0));
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
        end
        prev_rsp = rsp_valid;
    end

    // Present a command at a negedge and wait (bounded) for its acceptance; cmd_valid stays high
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, output logic rsp_at_accept);
        exp_t e;
        int   n;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        cmd_valid = 1'b1;
        if (w) begin
            for (int b = 0; b < SW; b++)
                if (s[b]) ref_mem[a[3:2]][8*b +: 8] = d[8*b +: 8];
            e.resp  = bresp_cfg;
            e.rdata = '0;
        end else begin
            e.resp  = rresp_cfg;
            e.rdata = ref_mem[a[3:2]];
        end
        sb_q.push_back(e);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 64'(cmd_ready), 64'(1));
        rsp_at_accept = rsp_valid;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic r, r2;
        int   s_aw, s_w, s_ar, s_awhi, s_whi, s_rsp;

        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({cmd_ready, rsp_valid, awvalid, wvalid, arvalid, bready, rready, timeout_err}), 64'(0));
        check("reset_regs", 64'({awaddr, araddr, wstrb, rsp_resp, awprot, arprot}), 64'(0));
        check("reset_data", 64'({wdata, rsp_rdata}), 64'(0));
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(cmd_ready), 64'(1));
        @(negedge clk);

        // Single write, both channels accepted in the same cycle
        s_aw = aw_hs_n; s_w = w_hs_n; s_awhi = aw_hi; s_whi = w_hi;
        issue(1'b1, 4'h4, 32'h0000_00A5, 4'hF, r);
        cmd_valid = 1'b0;
        wait_done();
        check("wr1_aw_hs", 64'(aw_hs_n - s_aw), 64'(1));
        check("wr1_w_hs", 64'(w_hs_n - s_w), 64'(1));
        check("wr1_awaddr", 64'(aw_a), 64'(4));
        check("wr1_aw_cycles", 64'(aw_hi - s_awhi), 64'(1));

        // Read back
        s_ar = ar_hs_n;
        issue(1'b0, 4'h4, '0, '0, r);
        cmd_valid = 1'b0;
        wait_done();
        check("rd1_ar_hs", 64'(ar_hs_n - s_ar), 64'(1));
        check("rd1_araddr", 64'(ar_a), 64'(4));

        // W accepted first, AW held four cycles; partial strobes
        aw_dly = 3;
        s_aw = aw_hs_n; s_w = w_hs_n; s_awhi = aw_hi; s_whi = w_hi;
        issue(1'b1, 4'h8, 32'h1234_5678, 4'b0101, r);
        cmd_valid = 1'b0;
        wait_done();
        aw_dly = 0;
        check("wr2_aw_cycles", 64'(aw_hi - s_awhi), 64'(4));
        check("wr2_w_cycles", 64'(w_hi - s_whi), 64'(1));
        check("wr2_aw_hs", 64'(aw_hs_n - s_aw), 64'(1));
        check("wr2_w_hs", 64'(w_hs_n - s_w), 64'(1));
        issue(1'b0, 4'h8, '0, '0, r);
        cmd_valid = 1'b0;
        wait_done();

        // AW first, W delayed; non-OKAY responses passed through
        w_dly = 2; bresp_cfg = RESP_SLVERR;
        s_awhi = aw_hi; s_whi = w_hi;
        issue(1'b1, 4'hC, 32'hDEAD_BEEF, 4'hF, r);
        cmd_valid = 1'b0;
        wait_done();
        w_dly = 0; bresp_cfg = RESP_OKAY;
        check("wr3_aw_cycles", 64'(aw_hi - s_awhi), 64'(1));
        check("wr3_w_cycles", 64'(w_hi - s_whi), 64'(3));
        ar_dly = 1; r_dly = 2; rresp_cfg = RESP_DECERR;
        issue(1'b0, 4'hC, '0, '0, r);
        cmd_valid = 1'b0;
        wait_done();
        ar_dly = 0; r_dly = 0; rresp_cfg = RESP_OKAY;
        check("no_timeout_yet", 64'(timeout_err), 64'(0));

        // Watchdog: BVALID withheld 20 cycles
        b_dly = 20;
        s_rsp = rsp_n;
        issue(1'b1, 4'h0, 32'h0000_0011, 4'hF, r);
        cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("wd_cycle16", 64'(timeout_err), 64'(0));
        @(negedge clk);
        check("wd_cycle17", 64'(timeout_err), 64'(1));
        check("wd_still_waiting", 64'({bready, rsp_n - s_rsp}), 64'({1'b1, 32'd0}));
        wait_done();
        b_dly = 0;
        check("wd_sticky", 64'(timeout_err), 64'(1));

        // Reset while ARVALID is high
        ar_dly = 10;
        s_ar = ar_hs_n;
        issue(1'b0, 4'h4, '0, '0, r);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_arvalid", 64'(arvalid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_drop", 64'({arvalid, cmd_ready, rsp_valid}), 64'(0));
        check("rst_err_clear", 64'(timeout_err), 64'(0));
        void'(sb_q.pop_back());
        s_rsp = rsp_n;
        ar_dly = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst2", 64'(cmd_ready), 64'(1));
        repeat (5) @(negedge clk);
        check("rst_no_rsp", 64'(rsp_n - s_rsp), 64'(0));
        check("rst_no_ar_hs", 64'(ar_hs_n - s_ar), 64'(0));

        // Back-to-back: second command accepted in the first one's rsp_valid cycle
        issue(1'b1, 4'hC, 32'h0BAD_F00D, 4'b1100, r);
        issue(1'b0, 4'hC, '0, '0, r2);
        cmd_valid = 1'b0;
        check("b2b_accept_in_rsp", 64'(r2), 64'(1));
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
